// File: rtl/arith_sched_pkg.sv
// Shared definitions for the arithmetic request scheduler and the arithmetic unit it feeds.
package arith_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_NEG = 4'd3;

    localparam int STAT_ERROR      = 3;
    localparam int STAT_NOT_EVEN_1 = 2;
    localparam int STAT_ZEROS      = 1;
    localparam int STAT_OVERFLOW   = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping to the lowest index when nothing at or above the pointer is requesting.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] hi_idx, lo_idx;
    logic          hi_any, lo_any;

    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        // descending scan so the lowest qualifying index is the one left standing
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lo_any = 1'b1;
                lo_idx = IW'(k);
            end
            if (req_i[k] && (k >= int'(ptr_i))) begin
                hi_any = 1'b1;
                hi_idx = IW'(k);
            end
        end
        idx_o = hi_any ? hi_idx : lo_idx;
        any_o = lo_any;
        gnt_o = '0;
        if (lo_any) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/sync_arith_unit_29.sv
// Single-stage arithmetic unit: add/sub/unsigned-divide/negate with a registered
// result and status. Status is {ERROR, NOT_EVEN_1 (result odd), ZEROS, OVERFLOW}.
module sync_arith_unit_29
    import arith_sched_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic [M-1:0] iarg_A,
    input  logic [M-1:0] iarg_B,
    input  logic [3:0]   iop,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    logic [M-1:0] res_d, result_q;
    logic         err_d, ovf_d;
    logic [3:0]   sts_d, status_q;

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        ovf_d = 1'b0;
        case (iop)
            OP_ADD: begin
                res_d = iarg_A + iarg_B;
                ovf_d = (iarg_A[M-1] == iarg_B[M-1]) && (res_d[M-1] != iarg_A[M-1]);
            end
            OP_SUB: begin
                res_d = iarg_A - iarg_B;
                ovf_d = (iarg_A[M-1] != iarg_B[M-1]) && (res_d[M-1] != iarg_A[M-1]);
            end
            OP_DIV: begin
                if (iarg_B == '0) err_d = 1'b1;
                else              res_d = iarg_A / iarg_B;
            end
            OP_NEG: begin
                res_d = '0 - iarg_A;
                // only the most negative value has no positive counterpart
                ovf_d = (iarg_A == {1'b1, {(M-1){1'b0}}});
            end
            default: err_d = 1'b1;
        endcase
        sts_d                  = '0;
        sts_d[STAT_ERROR]      = err_d;
        sts_d[STAT_NOT_EVEN_1] = res_d[0];
        sts_d[STAT_ZEROS]      = (res_d == '0);
        sts_d[STAT_OVERFLOW]   = ovf_d;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            result_q <= '0;
            status_q <= '0;
        end else begin
            result_q <= res_d;
            status_q <= sts_d;
        end
    end

    assign o_result = result_q;
    assign o_status = status_q;

endmodule

// File: rtl/arith_req_scheduler.sv
// Round-robin scheduler sharing one arithmetic unit between N_REQ requesters,
// one request in flight at a time: IDLE -> EXEC (LAT+1 cycles) -> RESP -> IDLE.
module arith_req_scheduler
    import arith_sched_pkg::*;
#(
    parameter int M     = 32,
    parameter int N_REQ = 4,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [4*N_REQ-1:0] i_req_op,
    input  logic [M*N_REQ-1:0] i_req_a,
    input  logic [M*N_REQ-1:0] i_req_b,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [M-1:0]       o_rsp_result,
    output logic [3:0]         o_rsp_status,
    input  logic [N_REQ-1:0]   i_rsp_ready,
    output logic [M-1:0]       o_unit_a,
    output logic [M-1:0]       o_unit_b,
    output logic [3:0]         o_unit_op,
    input  logic [M-1:0]       i_unit_result,
    input  logic [3:0]         i_unit_status,
    output logic               o_busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LAT + 1) + 1;

    logic [3:0]   req_op [N_REQ];
    logic [M-1:0] req_a  [N_REQ];
    logic [M-1:0] req_b  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign req_op[g] = i_req_op[4*g +: 4];
        assign req_a[g]  = i_req_a[M*g +: M];
        assign req_b[g]  = i_req_b[M*g +: M];
    end

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [M-1:0]       unit_a_q, unit_a_d;
    logic [M-1:0]       unit_b_q, unit_b_d;
    logic [3:0]         unit_op_q, unit_op_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [M-1:0]       rsp_result_q, rsp_result_d;
    logic [3:0]         rsp_status_q, rsp_status_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_op_d    = unit_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    unit_a_d  = req_a[arb_idx];
                    unit_b_d  = req_b[arb_idx];
                    unit_op_d = req_op[arb_idx];
                    grant_d   = arb_idx;
                    cnt_d     = '0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CW'(LAT)) begin
                    rsp_result_d         = i_unit_result;
                    rsp_status_d         = i_unit_status;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                // only the grantee's ready matters; the others are ignored
                if (i_rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_op_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_op_q    <= unit_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // ready is held low while reset is asserted so every output reads zero then
    assign o_req_ready  = (state_q == IDLE && i_reset) ? arb_gnt : '0;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_unit_a     = unit_a_q;
    assign o_unit_b     = unit_b_q;
    assign o_unit_op    = unit_op_q;
    assign o_busy       = (state_q != IDLE);

endmodule
